button_parser: RTL and testbench

Classifies each debounced button into one-cycle event pulses: short press, double press and long press. It sits directly downstream of `debouncer` and consumes its `debounced_signal` bus. Its pulses drive the user-control logic. Timing is measured in ticks from one shared prescaler, so millisecond-scale windows need only narrow per-button counters.

---
 rtl/button_parser_pkg.sv | 21 ++
 rtl/button_event_fsm.sv | 99 +++++++++
 rtl/button_parser.sv | 51 +++++
 tb/tb_button_parser.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/button_parser_pkg.sv
// Shared definitions for the button_parser slice: per-button state encoding and
// a sizing helper for the per-button tick counters.
package button_parser_pkg;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS1       = 2'd1;
    localparam logic [1:0] GAP          = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        StIdle        = IDLE,
        StPress1      = PRESS1,
        StGap         = GAP,
        StWaitRelease = WAIT_RELEASE
    } state_e;

    function automatic int unsigned max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_fsm.sv
// One button's event classifier: turns press/release timing, measured in shared
// prescaler ticks, into registered single-cycle short/double/long pulses.
module button_event_fsm
    import button_parser_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = 800,
    parameter int unsigned DOUBLE_TICKS = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic button,
    output logic short_press,
    output logic double_press,
    output logic long_press
);

    localparam int unsigned CNT_W = $clog2(max(LONG_TICKS, DOUBLE_TICKS) + 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] LongCnt = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] GapCnt  = CNT_W'(DOUBLE_TICKS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    // Release beats the long threshold and a second press beats the gap timeout,
    // because the button checks come before the tick checks.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (button) begin
                    state_d = StPress1;
                    cnt_d   = '0;
                end
            end
            StPress1: begin
                if (!button) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LongCnt) begin
                        state_d = StWaitRelease;
                        long_d  = 1'b1;
                    end
                end
            end
            StGap: begin
                if (button) begin
                    state_d  = StWaitRelease;
                    double_d = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == GapCnt) begin
                        state_d = StIdle;
                        short_d = 1'b1;
                    end
                end
            end
            StWaitRelease: begin
                if (!button) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StWaitRelease;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StWaitRelease;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
        end
    end

    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;

endmodule

// File: rtl/button_parser.sv
// Classifies each debounced button into short/double/long press pulses, with one
// tick prescaler shared by all per-button classifiers.
module button_parser
    import button_parser_pkg::*;
#(
    parameter int unsigned WIDTH        = 1,
    parameter int unsigned TICK_CNT_MAX = 125000,
    parameter int unsigned LONG_TICKS   = 800,
    parameter int unsigned DOUBLE_TICKS = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] short_press,
    output logic [WIDTH-1:0] double_press,
    output logic [WIDTH-1:0] long_press
);

    localparam int unsigned TICK_W = $clog2(TICK_CNT_MAX);
    localparam logic [TICK_W-1:0] TickLast = TICK_W'(TICK_CNT_MAX - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    assign tick       = (tick_cnt_q == TickLast);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_button
        button_event_fsm #(
            .LONG_TICKS   (LONG_TICKS),
            .DOUBLE_TICKS (DOUBLE_TICKS)
        ) u_fsm (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .button       (debounced_signal[i]),
            .short_press  (short_press[i]),
            .double_press (double_press[i]),
            .long_press   (long_press[i])
        );
    end

endmodule

// File: tb/tb_button_parser.sv
// Bench for button_parser: directed press sequences plus random traffic, compared
// cycle by cycle against a timestamp-based reference model.
module tb_button_parser;

    localparam int W   = 2;
    localparam int TCM = 4;
    localparam int LT  = 5;
    localparam int DT  = 3;

    // Model phases of a button's press sequence.
    localparam int UP     = 0;
    localparam int HELD   = 1;
    localparam int GAPPED = 2;
    localparam int IGNORE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic [W-1:0] short_press, double_press, long_press;

    button_parser #(
        .WIDTH        (W),
        .TICK_CNT_MAX (TCM),
        .LONG_TICKS   (LT),
        .DOUBLE_TICKS (DT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .debounced_signal (din),
        .short_press      (short_press),
        .double_press     (double_press),
        .long_press       (long_press)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: events derive from the global tick count elapsed since the
    // press or release that opened the current phase.
    int           prescale = 0;
    int           ticks    = 0;
    int           mode[W];
    int           mark[W];
    logic [W-1:0] exp_s = '0, exp_d = '0, exp_l = '0;
    int           n_s[W], n_d[W], n_l[W];

    function automatic void model_edge();
        bit t;
        t     = (prescale == TCM - 1);
        exp_s = '0;
        exp_d = '0;
        exp_l = '0;
        if (rst) begin
            prescale = 0;
            ticks    = 0;
            for (int i = 0; i < W; i++) mode[i] = IGNORE;
            return;
        end
        prescale = (prescale + 1) % TCM;
        if (t) ticks++;
        for (int i = 0; i < W; i++) begin
            case (mode[i])
                UP: if (din[i]) begin
                    mode[i] = HELD;
                    mark[i] = ticks;
                end
                HELD: if (!din[i]) begin
                    mode[i] = GAPPED;
                    mark[i] = ticks;
                end else if (t && ticks - mark[i] == LT) begin
                    exp_l[i] = 1'b1;
                    mode[i]  = IGNORE;
                end
                GAPPED: if (din[i]) begin
                    exp_d[i] = 1'b1;
                    mode[i]  = IGNORE;
                end else if (t && ticks - mark[i] == DT) begin
                    exp_s[i] = 1'b1;
                    mode[i]  = UP;
                end
                default: if (!din[i]) mode[i] = UP;
            endcase
        end
    endfunction

    task automatic clear_tally();
        for (int i = 0; i < W; i++) begin
            n_s[i] = 0;
            n_d[i] = 0;
            n_l[i] = 0;
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] d);
        rst = r;
        din = d;
        model_edge();
        @(posedge clk);
        #1;
        check("short_press", short_press, exp_s);
        check("double_press", double_press, exp_d);
        check("long_press", long_press, exp_l);
        for (int i = 0; i < W; i++) begin
            n_s[i] += int'(short_press[i]);
            n_d[i] += int'(double_press[i]);
            n_l[i] += int'(long_press[i]);
        end
    endtask

    task automatic run(input int n, input logic r, input logic [W-1:0] d);
        repeat (n) step(r, d);
    endtask

    task automatic tally(input string tag, input int b, input int s, input int dd, input int l);
        check({tag, "_short"}, n_s[b], s);
        check({tag, "_double"}, n_d[b], dd);
        check({tag, "_long"}, n_l[b], l);
    endtask

    initial begin
        for (int i = 0; i < W; i++) begin
            mode[i] = IGNORE;
            mark[i] = 0;
        end
        clear_tally();

        // Button held through reset produces nothing; a later short press works.
        run(3, 1'b1, 2'b01);
        run(40, 1'b0, 2'b01);
        run(5, 1'b0, 2'b00);
        tally("held_reset", 0, 0, 0, 0);
        clear_tally();
        run(8, 1'b0, 2'b01);
        run(20, 1'b0, 2'b00);
        tally("short", 0, 1, 0, 0);
        tally("short_b1", 1, 0, 0, 0);

        clear_tally();
        run(40, 1'b0, 2'b01);
        run(10, 1'b0, 2'b00);
        tally("long", 0, 0, 0, 1);

        clear_tally();
        run(6, 1'b0, 2'b01);
        run(5, 1'b0, 2'b00);
        run(6, 1'b0, 2'b01);
        run(20, 1'b0, 2'b00);
        tally("double", 0, 0, 1, 0);

        // Overlapping long press on button 0 and short press on button 1.
        clear_tally();
        run(10, 1'b0, 2'b01);
        run(8, 1'b0, 2'b11);
        run(22, 1'b0, 2'b01);
        run(20, 1'b0, 2'b00);
        tally("indep_b0", 0, 0, 0, 1);
        tally("indep_b1", 1, 1, 0, 0);

        clear_tally();
        run(6, 1'b0, 2'b01);
        run(1, 1'b0, 2'b00);
        run(1, 1'b1, 2'b00);
        run(25, 1'b0, 2'b00);
        tally("reset_gap", 0, 0, 0, 0);

        // Random traffic with occasional resets.
        begin
            logic [W-1:0] d;
            logic         r;
            d = '0;
            for (int c = 0; c < 4000; c++) begin
                for (int i = 0; i < W; i++) begin
                    if ($urandom_range(0, 9) == 0) d[i] = ~d[i];
                end
                r = ($urandom_range(0, 599) == 0);
                step(r, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
